// File: rtl/mat_pkg.sv
// mat_pkg: shared constants and state encoding for the 3x3/2x2 matrix loader
package mat_pkg;
  localparam int ELEM_W = 8;
  localparam int N_ELEM = 9;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2} state_t;
  localparam logic SIZE_3X3 = 1'b0;
  localparam logic SIZE_2X2 = 1'b1;
  localparam logic [3:0] TGT_3X3 = 4'd9;
  localparam logic [3:0] TGT_2X2 = 4'd4;
  localparam logic [N_ELEM*ELEM_W-1:0] PAD_2X2 = 72'h01;
endpackage

// File: rtl/mat_idx_map.sv
// mat_idx_map: maps element ordinal k to its row-major byte slot in the 3x3 frame
module mat_idx_map
  import mat_pkg::*;
(
  input  logic       size,
  input  logic [3:0] k,
  output logic [3:0] slot
);
  // 2x2 elements skip column 2 of row 0, so k=2,3 land on slots 3,4
  always_comb slot = (size == SIZE_2X2) ? k + {3'b000, k[1]} : k;
endmodule

// File: rtl/mat_load3.sv
// mat_load3: collects a row-major stream of signed elements into a packed 3x3 matrix
module mat_load3 #(
  parameter int ELEM_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  size,
  input  logic                  in_valid,
  input  logic [ELEM_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [9*ELEM_W-1:0]   m,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [3:0]            count
);
  import mat_pkg::*;
  state_t              state_q, state_d;
  logic                size_q, size_d;
  logic [3:0]          count_q, count_d, slot, tgt;
  logic [9*ELEM_W-1:0] m_q, m_d;
  logic                accept;
  assign accept = in_valid && in_ready;
  assign tgt    = (size_q == SIZE_2X2) ? TGT_2X2 : TGT_3X3;
  assign m      = m_q;
  assign count  = count_q;
  mat_idx_map u_map (.size(size_q), .k(count_q), .slot(slot));
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next-state: start only honoured in IDLE, last accept fills, handshake drains
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && count_q == tgt - 4'd1) state_d = FULL;
      FULL:    if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are pure decodes of the registered state
  always_comb begin
    in_ready = state_q == LOAD;
    m_valid  = state_q == FULL;
    busy     = state_q != IDLE;
  end
  // datapath registers: size latch, element counter, matrix bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q  <= SIZE_3X3;
      count_q <= 4'd0;
      m_q     <= '0;
    end else begin
      size_q  <= size_d;
      count_q <= count_d;
      m_q     <= m_d;
    end
  end
  // start preloads padding; each accept drops the element into its mapped slot
  always_comb begin
    size_d  = size_q;
    count_d = count_q;
    m_d     = m_q;
    if (state_q == IDLE && start) begin
      size_d  = size;
      count_d = 4'd0;
      m_d     = (size == SIZE_2X2) ? PAD_2X2 : '0;
    end
    if (accept) begin
      count_d = count_q + 4'd1;
      for (int i = 0; i < 9; i++)
        if (slot == 4'(i)) m_d[ELEM_W*(8-i) +: ELEM_W] = in_data;
    end
  end
endmodule

// File: doc/mat_load3.md
MAT_LOAD3 -- requirements
Module: mat_load3

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 8, meaning signed matrix element width in bits; only 8 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle request to begin a new matrix load.
REQ-005 The block SHALL have port size, input, 1 bit: dimension select sampled with start; 0 = 3x3, 1 = 2x2.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data holds a valid element.
REQ-007 The block SHALL have port in_data, input, 8 bits: signed element, row-major order.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 The block SHALL have port m, output, 72 bits: packed 3x3 matrix, a00 at [71:64] through a22 at [7:0], row-major.
REQ-010 The block SHALL have port m_valid, output, 1 bit: m is complete and stable.
REQ-011 The block SHALL have port m_ready, input, 1 bit: downstream determinant stage consumes m.
REQ-012 The block SHALL have port busy, output, 1 bit: high in LOAD or FULL.
REQ-013 The block SHALL have port count, output, 4 bits: number of elements accepted in the current load.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD and FULL.
REQ-015 In IDLE with start=1, the FSM SHALL go to LOAD and latch size; count SHALL be cleared to 0.
REQ-016 On that same edge, m SHALL be loaded with the padding pattern: 3x3 gives all zero; 2x2 gives all zero except a22 = 8'h01.
REQ-017 start SHALL be ignored in LOAD and FULL.
REQ-018 in_ready SHALL equal 1 only in LOAD; it is a registered-state decode with no combinational path from in_valid.
REQ-019 An element SHALL be accepted on an edge where in_valid && in_ready; count increments by 1.
REQ-020 In 3x3 mode, accepted element k (0..8) SHALL be written to m[71-8k -: 8].
REQ-021 In 2x2 mode, elements k = 0..3 SHALL be written to a00, a01, a10 and a11 ([71:64], [63:56], [47:40], [39:32]); all other bytes keep the padding.
REQ-022 Acceptance of the last element (k=8 for 3x3, k=3 for 2x2) SHALL move the FSM to FULL; m_valid SHALL be 1 on the next cycle, giving 1-cycle latency.
REQ-023 Gaps in in_valid SHALL only stall the load, with no other effect.
REQ-024 In FULL, m_valid SHALL be 1 and m SHALL be held bit-stable until the handshake.
REQ-025 m_valid && m_ready in FULL SHALL return the FSM to IDLE; m_valid drops on the next cycle and m retains its last value.
REQ-026 start asserted in the same cycle as the FULL handshake SHALL be ignored; a new load requires start while in IDLE.
REQ-027 m_ready outside FULL SHALL be ignored.
REQ-028 count SHALL saturate at its terminal value (9 or 4) while in FULL.
REQ-029 Elements are stored unmodified, with no sign extension or arithmetic; the 2x2 padding makes a 3x3 determinant equal the 2x2 determinant.

Reset
REQ-030 rst=1 SHALL force, asynchronously and regardless of state: IDLE, m=0, m_valid=0, in_ready=0, busy=0, count=0, latched size=0.
REQ-031 Reset mid-LOAD or mid-FULL SHALL discard the partial or complete matrix; no m_valid follows without a new start.

Structure
REQ-032 Shared package mat_pkg SHALL hold ELEM_W, the state encoding (IDLE/LOAD/FULL), SIZE_3X3=0 and SIZE_2X2=1, element targets 9 and 4, and the 2x2 padding constant.
REQ-033 Sub-module mat_idx_map SHALL be combinational and map (size, k) to the byte slot index 0..8; it is the only sub-module.

Verification
REQ-034 3x3: start size=0, then 1..9 back-to-back -> m=72'h010203040506070809, m_valid on the cycle after the 9th accept, count=9.
REQ-035 2x2: start size=1, then 3,4,5,6 -> m=72'h030400050600000001, m_valid set; downstream det equals -2.
REQ-036 Backpressure: m_ready=0 for 5 cycles after FULL -> m and m_valid stable, in_ready=0; m_ready=1 -> IDLE next cycle, m_valid=0.
REQ-037 Stalls and negatives: 3x3 with in_valid low on alternate cycles, data 8'h80, 8'h7F, 8'hFF, ... -> bytes stored verbatim in order, count advances only on accepts.
REQ-038 Reset mid-load: after 4 of 9 elements, pulse rst asynchronously between edges -> outputs zero immediately; a new start loads cleanly from k=0.
REQ-039 Ignored start: start pulse during LOAD after 2 elements with size=1 -> mode stays 3x3 and the load completes after 9 elements.
